// File: rtl/axi4s_pkt_gen.sv
// rtl/axi4s_pkt_gen.sv - AXI4-Stream packet generator, optional tail keep via AXIS_PKT_GEN_TAIL_EN
module axi4s_pkt_gen #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 8,
  parameter int DEST_W = 2,
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 8
) (
  input  logic                     ACLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     EN,
  input  logic [1:0]               MODE,
  input  logic [LEN_W-1:0]         PKT_LEN,
  input  logic [15:0]              NUM_PKTS,
`ifdef AXIS_PKT_GEN_TAIL_EN
  input  logic [$clog2(DATA_W/8):0] TAIL_BYTES,
`endif
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     TVALID,
  input  logic                     TREADY,
  output logic [DATA_W-1:0]        TDATA,
  output logic                     TLAST,
  output logic [DATA_W/8-1:0]      TKEEP,
  output logic [DATA_W/8-1:0]      TSTRB,
  output logic [ID_W-1:0]          TID,
  output logic [DEST_W-1:0]        TDEST
);

  localparam int KB = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_FIN} state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic [KB-1:0]       tkeep_q, tkeep_d;
  logic [ID_W-1:0]     tid_q, tid_d;
  logic [DEST_W-1:0]   tdest_q, tdest_d;
  logic [1:0]          mode_q, mode_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [15:0]         npkts_q, npkts_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [15:0]         pkt_q, pkt_d;
  logic [DEST_W-1:0]   ch_q, ch_d;
  logic                final_q, final_d;
  logic                armed_q, armed_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [31:0]         cnt_q [NUM_CH];
  logic [31:0]         cnt_d [NUM_CH];
`ifdef AXIS_PKT_GEN_TAIL_EN
  logic [$clog2(KB):0] tail_q, tail_d;
  logic [$clog2(KB):0] cfg_tail;
`endif

  logic                in_idle;
  logic [1:0]          cfg_mode;
  logic [LEN_W-1:0]    cfg_len;
  logic [LEN_W-1:0]    len_eff;
  logic [15:0]         cfg_np;
  logic [LEN_W-1:0]    pos_beat;
  logic [15:0]         pos_pkt;
  logic [DEST_W-1:0]   pos_ch;
  logic                last_beat;
  logic                last_pkt;
  logic [31:0]         word;
  logic [DATA_W-1:0]   data_w;
  logic [KB-1:0]       keep_w;
  logic                fire;
  logic                issue;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    // Galois form of x^32+x^22+x^2+x+1, shifting right
    lfsr_step = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [DATA_W-1:0] rep32(input logic [31:0] w);
    rep32 = '0;
    for (int i = 0; i < DATA_W; i++) rep32[i] = w[i % 32];
  endfunction

  // Field values of the beat that would be issued now; a START in IDLE issues from the live inputs
  always_comb begin
    in_idle   = (state_q == S_IDLE);
    cfg_mode  = in_idle ? MODE : mode_q;
    cfg_len   = in_idle ? PKT_LEN : len_q;
    cfg_np    = in_idle ? NUM_PKTS : npkts_q;
    pos_beat  = in_idle ? '0 : beat_q;
    pos_pkt   = in_idle ? '0 : pkt_q;
    pos_ch    = in_idle ? '0 : ch_q;
    len_eff   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    last_beat = (pos_beat == len_eff - LEN_W'(1));
    last_pkt  = (cfg_np != 16'd0) && (pos_pkt == cfg_np - 16'd1);
    case (cfg_mode)
      2'b01:   word = lfsr_q;
      2'b10:   word = {8'(pos_ch), 8'(pos_pkt), 16'(pos_beat)};
      default: word = cnt_q[pos_ch];
    endcase
    data_w = rep32(word);
    keep_w = '1;
`ifdef AXIS_PKT_GEN_TAIL_EN
    cfg_tail = in_idle ? TAIL_BYTES : tail_q;
    if (last_beat && (cfg_tail != '0) && (int'(cfg_tail) < KB)) begin
      for (int i = 0; i < KB; i++) begin
        keep_w[i] = (i < int'(cfg_tail));
        data_w[8*i +: 8] = data_w[8*i +: 8] & {8{keep_w[i]}};
      end
    end
`endif
  end

  // Next-state: run control, beat issue under backpressure, counter advance
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tid_d    = tid_q;
    tdest_d  = tdest_q;
    mode_d   = mode_q;
    len_d    = len_q;
    npkts_d  = npkts_q;
    beat_d   = beat_q;
    pkt_d    = pkt_q;
    ch_d     = ch_q;
    final_d  = final_q;
    armed_d  = 1'b1;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
`ifdef AXIS_PKT_GEN_TAIL_EN
    tail_d   = tail_q;
`endif
    fire  = tvalid_q && TREADY;
    issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START && armed_q) begin
          mode_d  = MODE;
          len_d   = PKT_LEN;
          npkts_d = NUM_PKTS;
`ifdef AXIS_PKT_GEN_TAIL_EN
          tail_d  = TAIL_BYTES;
`endif
          busy_d  = 1'b1;
          state_d = S_SEND;
          beat_d  = '0;
          pkt_d   = '0;
          ch_d    = '0;
          final_d = 1'b0;
          issue   = EN;
        end
      end
      S_SEND: begin
        if (fire) tvalid_d = 1'b0;
        if (fire && final_q) state_d = S_FIN;
        else if (EN && !final_q && (!tvalid_q || fire)) issue = 1'b1;
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      tvalid_d = 1'b1;
      tlast_d  = last_beat;
      tdata_d  = data_w;
      tkeep_d  = keep_w;
      tid_d    = ID_W'(pos_pkt);
      tdest_d  = pos_ch;
      final_d  = last_beat && last_pkt;
      lfsr_d   = lfsr_step(lfsr_q);
      cnt_d[pos_ch] = cnt_q[pos_ch] + 32'd1;
      if (last_beat) begin
        beat_d = '0;
        pkt_d  = pos_pkt + 16'd1;
        ch_d   = (pos_ch == DEST_W'(NUM_CH - 1)) ? '0 : pos_ch + DEST_W'(1);
      end else begin
        beat_d = pos_beat + LEN_W'(1);
        pkt_d  = pos_pkt;
        ch_d   = pos_ch;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge ACLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tid_q    <= '0;
      tdest_q  <= '0;
      mode_q   <= '0;
      len_q    <= '0;
      npkts_q  <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      ch_q     <= '0;
      final_q  <= 1'b0;
      armed_q  <= 1'b0;
      lfsr_q   <= 32'hFFFF_FFFF;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
`ifdef AXIS_PKT_GEN_TAIL_EN
      tail_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tid_q    <= tid_d;
      tdest_q  <= tdest_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      npkts_q  <= npkts_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      ch_q     <= ch_d;
      final_q  <= final_d;
      armed_q  <= armed_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
`ifdef AXIS_PKT_GEN_TAIL_EN
      tail_q   <= tail_d;
`endif
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign TVALID = tvalid_q;
  assign TLAST  = tlast_q;
  assign TDATA  = tdata_q;
  assign TKEEP  = tkeep_q;
  assign TSTRB  = tkeep_q;
  assign TID    = tid_q;
  assign TDEST  = tdest_q;

endmodule

// File: tb/tb_axi4s_pkt_gen.sv
// tb/tb_axi4s_pkt_gen.sv - directed self-checking bench for axi4s_pkt_gen
module tb_axi4s_pkt_gen;

  logic        ACLK = 1'b0;
  logic        RST;
  logic        START;
  logic        EN;
  logic [1:0]  MODE;
  logic [7:0]  PKT_LEN;
  logic [15:0] NUM_PKTS;
`ifdef AXIS_PKT_GEN_TAIL_EN
  logic [2:0]  TAIL_BYTES;
`endif
  logic        BUSY, DONE, TVALID, TREADY, TLAST;
  logic [31:0] TDATA;
  logic [3:0]  TKEEP, TSTRB;
  logic [7:0]  TID;
  logic [1:0]  TDEST;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  axi4s_pkt_gen dut (
    .ACLK(ACLK), .RST(RST), .START(START), .EN(EN), .MODE(MODE),
    .PKT_LEN(PKT_LEN), .NUM_PKTS(NUM_PKTS),
`ifdef AXIS_PKT_GEN_TAIL_EN
    .TAIL_BYTES(TAIL_BYTES),
`endif
    .BUSY(BUSY), .DONE(DONE), .TVALID(TVALID), .TREADY(TREADY),
    .TDATA(TDATA), .TLAST(TLAST), .TKEEP(TKEEP), .TSTRB(TSTRB),
    .TID(TID), .TDEST(TDEST)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; START = 1'b0; EN = 1'b1; TREADY = 1'b1;
    step();
    RST = 1'b0;
    step();
    step();
  endtask

  initial begin
    int k;
    int seen;
    logic pv;
    logic [31:0] sd;
    logic [7:0] sid;
    logic sl;
    logic [1:0] sdst;

    RST = 1'b1; START = 1'b0; EN = 1'b0; MODE = 2'b00; PKT_LEN = 8'd0;
    NUM_PKTS = 16'd0; TREADY = 1'b0;
`ifdef AXIS_PKT_GEN_TAIL_EN
    TAIL_BYTES = 3'd0;
`endif
    step();
    check("rst_tvalid", 32'(TVALID), 0);
    check("rst_tlast",  32'(TLAST), 0);
    check("rst_busy",   32'(BUSY), 0);
    check("rst_done",   32'(DONE), 0);
    check("rst_tdata",  TDATA, 0);
    check("rst_tkeep",  32'(TKEEP), 0);
    check("rst_tid",    32'(TID), 0);
    check("rst_tdest",  32'(TDEST), 0);

    // Test 1: INC, 2 packets of 4, full throughput
    do_reset();
    MODE = 2'b00; PKT_LEN = 8'd4; NUM_PKTS = 16'd2; START = 1'b1;
    step();
    START = 1'b0;
    for (int b = 0; b < 8; b++) begin
      check("t1_tvalid", 32'(TVALID), 1);
      check("t1_busy",   32'(BUSY), 1);
      check("t1_tdata",  TDATA, 32'(b % 4));
      check("t1_tlast",  32'(TLAST), 32'((b % 4) == 3));
      check("t1_tdest",  32'(TDEST), 32'(b / 4));
      check("t1_tid",    32'(TID), 32'(b / 4));
      check("t1_tkeep",  32'(TKEEP), 32'hF);
      check("t1_tstrb",  32'(TSTRB), 32'hF);
      step();
    end
    check("t1_tvalid_end", 32'(TVALID), 0);
    check("t1_done_early", 32'(DONE), 0);
    step();
    check("t1_done", 32'(DONE), 1);
    check("t1_busy_low", 32'(BUSY), 0);
    step();
    check("t1_done_pulse", 32'(DONE), 0);

    // Test 2: HDR, random TREADY, 5 packets of 3
    do_reset();
    MODE = 2'b10; PKT_LEN = 8'd3; NUM_PKTS = 16'd5; START = 1'b1;
    step();
    START = 1'b0;
    k = 0; pv = 1'b0; sd = '0; sid = '0; sl = 1'b0; sdst = '0;
    for (int c = 0; c < 300 && k < 15; c++) begin
      if (pv) begin
        check("t2_hold_valid", 32'(TVALID), 1);
        check("t2_hold_data",  TDATA, sd);
        check("t2_hold_last",  32'(TLAST), 32'(sl));
        check("t2_hold_tid",   32'(TID), 32'(sid));
        check("t2_hold_tdest", 32'(TDEST), 32'(sdst));
      end
      TREADY = 1'($urandom_range(0, 1));
      if (TVALID && TREADY) begin
        check("t2_tdata", TDATA, {8'((k / 3) % 4), 8'(k / 3), 16'(k % 3)});
        check("t2_tlast", 32'(TLAST), 32'((k % 3) == 2));
        check("t2_tdest", 32'(TDEST), 32'((k / 3) % 4));
        check("t2_tid",   32'(TID), 32'(k / 3));
        k++;
      end
      pv = TVALID && !TREADY; sd = TDATA; sl = TLAST; sid = TID; sdst = TDEST;
      step();
    end
    check("t2_count", 32'(k), 15);
    TREADY = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (DONE) seen = 1;
      step();
    end
    check("t2_done_seen", 32'(seen), 1);

    // Test 3: EN dropped while a beat is stalled
    do_reset();
    MODE = 2'b00; PKT_LEN = 8'd4; NUM_PKTS = 16'd1; TREADY = 1'b0; START = 1'b1;
    step();
    START = 1'b0; EN = 1'b0;
    check("t3_valid_a", 32'(TVALID), 1);
    check("t3_data_a",  TDATA, 0);
    step();
    check("t3_valid_b", 32'(TVALID), 1);
    check("t3_data_b",  TDATA, 0);
    TREADY = 1'b1;
    step();
    check("t3_no_issue_a", 32'(TVALID), 0);
    step();
    check("t3_no_issue_b", 32'(TVALID), 0);
    EN = 1'b1;
    step();
    check("t3_resume_valid", 32'(TVALID), 1);
    check("t3_resume_data",  TDATA, 1);
    for (int c = 0; c < 5; c++) step();

    // Test 4: LFSR, single-beat packets, START while busy
    do_reset();
    MODE = 2'b01; PKT_LEN = 8'd1; NUM_PKTS = 16'd3; START = 1'b1;
    step();
    START = 1'b0;
    check("t4_data0", TDATA, 32'hFFFF_FFFF);
    check("t4_last0", 32'(TLAST), 1);
    check("t4_dest0", 32'(TDEST), 0);
    START = 1'b1;
    step();
    START = 1'b0;
    check("t4_data1", TDATA, 32'hFFDF_FFFC);
    check("t4_last1", 32'(TLAST), 1);
    check("t4_dest1", 32'(TDEST), 1);
    step();
    check("t4_data2", TDATA, 32'h7FEF_FFFE);
    check("t4_last2", 32'(TLAST), 1);
    check("t4_dest2", 32'(TDEST), 2);
    step();
    check("t4_valid_end", 32'(TVALID), 0);
    step();
    check("t4_done", 32'(DONE), 1);
    check("t4_busy", 32'(BUSY), 0);
    step();
    check("t4_idle_valid", 32'(TVALID), 0);
    check("t4_idle_busy",  32'(BUSY), 0);

    // Test 5: reset mid-packet, then restart
    do_reset();
    MODE = 2'b00; PKT_LEN = 8'd8; NUM_PKTS = 16'd1; START = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    check("t5_beat2", TDATA, 2);
    RST = 1'b1;
    #1;
    check("t5_rst_valid", 32'(TVALID), 0);
    check("t5_rst_last",  32'(TLAST), 0);
    check("t5_rst_busy",  32'(BUSY), 0);
    check("t5_rst_data",  TDATA, 0);
    check("t5_rst_keep",  32'(TKEEP), 0);
    step();
    RST = 1'b0;
    step();
    step();
    START = 1'b1;
    step();
    START = 1'b0;
    check("t5_restart_valid", 32'(TVALID), 1);
    check("t5_restart_data0", TDATA, 0);
    step();
    check("t5_restart_data1", TDATA, 1);
    for (int c = 0; c < 10; c++) step();

`ifdef AXIS_PKT_GEN_TAIL_EN
    // Test 6: partial keep on the last beat
    do_reset();
    MODE = 2'b01; PKT_LEN = 8'd2; NUM_PKTS = 16'd1; TAIL_BYTES = 3'd3; START = 1'b1;
    step();
    START = 1'b0;
    check("t6_keep0", 32'(TKEEP), 32'hF);
    check("t6_data0", TDATA, 32'hFFFF_FFFF);
    step();
    check("t6_keep1", 32'(TKEEP), 32'h7);
    check("t6_strb1", 32'(TSTRB), 32'h7);
    check("t6_data1", TDATA, 32'h00DF_FFFC);
    check("t6_last1", 32'(TLAST), 1);
    for (int c = 0; c < 4; c++) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
